// File: rtl/br_ram_pkg.sv
// rtl/br_ram_pkg.sv - latency helpers shared by flop RAMs and the FIFO controllers driving them
package br_ram_pkg;

    // Cycles from rd_addr_valid to rd_data_valid.
    function automatic int br_ram_read_latency(input int address_stages, input int read_data_stages);
        return address_stages + read_data_stages;
    endfunction

    // Cycles from wr_valid until the entry is visible to a read at the array stage.
    function automatic int br_ram_write_latency(input int address_stages);
        return address_stages + 1;
    endfunction

endpackage

// File: rtl/br_delay_valid_rst_n.sv
// rtl/br_delay_valid_rst_n.sv - valid+data delay line with async active-low reset
// Data is forced to zero whenever its valid is low, so idle stages never carry stale or X data.
module br_delay_valid_rst_n #(
    parameter int NumStages = 0,
    parameter int Width     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [Width-1:0] in_data,
    output logic             out_valid,
    output logic [Width-1:0] out_data
);

    if (NumStages == 0) begin : g_passthru
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
        assign out_valid      = in_valid;
        assign out_data       = in_valid ? in_data : '0;
    end else begin : g_pipe
        logic [NumStages-1:0]            valid_q;
        logic [NumStages-1:0]            valid_d;
        logic [NumStages-1:0][Width-1:0] data_q;
        logic [NumStages-1:0][Width-1:0] data_d;

        always_comb begin
            valid_d    = '0;
            data_d     = '0;
            valid_d[0] = in_valid;
            data_d[0]  = in_valid ? in_data : '0;
            for (int i = 1; i < NumStages; i++) begin
                valid_d[i] = valid_q[i-1];
                data_d[i]  = valid_q[i-1] ? data_q[i-1] : '0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= '0;
                data_q  <= '0;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
            end
        end

        assign out_valid = valid_q[NumStages-1];
        assign out_data  = data_q[NumStages-1];
    end

endmodule

// File: rtl/br_ram_flops_1r1w_sync.sv
// rtl/br_ram_flops_1r1w_sync.sv - single-clock 1R1W flop RAM with pipelined address and read-data paths
// Optional macro BR_RAM_FLOPS_WR_RD_BYPASS_EN: same-address write forwards to a same-cycle read.
module br_ram_flops_1r1w_sync
    import br_ram_pkg::*;
#(
    parameter  int Depth          = 2,
    parameter  int Width          = 1,
    parameter  int AddressStages  = 0,
    parameter  int ReadDataStages = 0,
    parameter  int EnableMemReset = 0,
    localparam int AddrWidth      = $clog2(Depth)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_valid,
    input  logic [AddrWidth-1:0] wr_addr,
    input  logic [Width-1:0]     wr_data,
    input  logic                 rd_addr_valid,
    input  logic [AddrWidth-1:0] rd_addr,
    output logic                 rd_data_valid,
    output logic [Width-1:0]     rd_data
);

    // The array register is the final write stage, so the write pipe holds one less.
    localparam int WrPipeStages = br_ram_write_latency(AddressStages) - 1;
    localparam int RdDataPipe   = br_ram_read_latency(AddressStages, ReadDataStages) - AddressStages;

    if (Depth < 2) begin : g_bad_depth
        $error("br_ram_flops_1r1w_sync: Depth must be >= 2");
    end
    if (Width < 1) begin : g_bad_width
        $error("br_ram_flops_1r1w_sync: Width must be >= 1");
    end
    if (AddressStages < 0 || ReadDataStages < 0) begin : g_bad_stages
        $error("br_ram_flops_1r1w_sync: stage counts must be >= 0");
    end

    logic                       wr_valid_s;
    logic [AddrWidth-1:0]       wr_addr_s;
    logic [Width-1:0]           wr_data_s;
    logic [AddrWidth+Width-1:0] wr_pipe_data;

    br_delay_valid_rst_n #(
        .NumStages(WrPipeStages),
        .Width    (AddrWidth + Width)
    ) u_wr_delay (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (wr_valid),
        .in_data  ({wr_addr, wr_data}),
        .out_valid(wr_valid_s),
        .out_data (wr_pipe_data)
    );

    assign {wr_addr_s, wr_data_s} = wr_pipe_data;

    logic                 rd_valid_s;
    logic [AddrWidth-1:0] rd_addr_s;

    br_delay_valid_rst_n #(
        .NumStages(AddressStages),
        .Width    (AddrWidth)
    ) u_rd_addr_delay (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (rd_addr_valid),
        .in_data  (rd_addr),
        .out_valid(rd_valid_s),
        .out_data (rd_addr_s)
    );

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];

    always_comb begin
        mem_d = mem_q;
        if (wr_valid_s) begin
            mem_d[wr_addr_s] = wr_data_s;
        end
    end

    if (EnableMemReset != 0) begin : g_mem_rst
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mem_q <= '{default: '0};
            end else begin
                mem_q <= mem_d;
            end
        end
    end else begin : g_mem_no_rst
        always_ff @(posedge clk) begin
            mem_q <= mem_d;
        end
    end

    logic [Width-1:0] rd_word;

    always_comb begin
        rd_word = '0;
        if (rd_valid_s) begin
            rd_word = mem_q[rd_addr_s];
`ifdef BR_RAM_FLOPS_WR_RD_BYPASS_EN
            if (wr_valid_s && (wr_addr_s == rd_addr_s)) begin
                rd_word = wr_data_s;
            end
`endif
        end
    end

    br_delay_valid_rst_n #(
        .NumStages(RdDataPipe),
        .Width    (Width)
    ) u_rd_data_delay (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (rd_valid_s),
        .in_data  (rd_word),
        .out_valid(rd_data_valid),
        .out_data (rd_data)
    );

    localparam logic [AddrWidth:0] DepthLimit = (AddrWidth + 1)'(Depth);

    a_wr_addr_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        wr_valid |-> ({1'b0, wr_addr} < DepthLimit));

    a_rd_addr_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        rd_addr_valid |-> ({1'b0, rd_addr} < DepthLimit));

    a_valids_known: assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown({wr_valid, rd_addr_valid}));

`ifndef BR_RAM_FLOPS_WR_RD_BYPASS_EN
    c_same_addr_collision: cover property (@(posedge clk) disable iff (!rst_n)
        wr_valid_s && rd_valid_s && (wr_addr_s == rd_addr_s));
`endif

endmodule

// File: tb/tb_br_ram_flops_1r1w_sync.sv
// tb/tb_br_ram_flops_1r1w_sync.sv - bench for br_ram_flops_1r1w_sync across three configurations
module tb_br_ram_flops_1r1w_sync;

    localparam int NI = 3;
    // inst0: 8x16 stages 0/0; inst1: 8x16 stages 2/1 with mem reset; inst2: 4x16 stages 1/2
    localparam int DEP [NI] = '{8, 8, 4};
    localparam int LAT [NI] = '{0, 3, 3};
    localparam int EMR [NI] = '{0, 1, 0};
`ifdef BR_RAM_FLOPS_WR_RD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        wv  [NI];
    logic [2:0]  wa  [NI];
    logic [15:0] wd  [NI];
    logic        rv  [NI];
    logic [2:0]  ra  [NI];
    logic        rdv [NI];
    logic [15:0] rdd [NI];
    wire unused_bits = wa[2][2] ^ ra[2][2];

    br_ram_flops_1r1w_sync #(.Depth(8), .Width(16), .AddressStages(0), .ReadDataStages(0), .EnableMemReset(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .wr_valid(wv[0]), .wr_addr(wa[0]), .wr_data(wd[0]),
        .rd_addr_valid(rv[0]), .rd_addr(ra[0]), .rd_data_valid(rdv[0]), .rd_data(rdd[0]));

    br_ram_flops_1r1w_sync #(.Depth(8), .Width(16), .AddressStages(2), .ReadDataStages(1), .EnableMemReset(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .wr_valid(wv[1]), .wr_addr(wa[1]), .wr_data(wd[1]),
        .rd_addr_valid(rv[1]), .rd_addr(ra[1]), .rd_data_valid(rdv[1]), .rd_data(rdd[1]));

    br_ram_flops_1r1w_sync #(.Depth(4), .Width(16), .AddressStages(1), .ReadDataStages(2), .EnableMemReset(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .wr_valid(wv[2]), .wr_addr(wa[2][1:0]), .wr_data(wd[2]),
        .rd_addr_valid(rv[2]), .rd_addr(ra[2][1:0]), .rd_data_valid(rdv[2]), .rd_data(rdd[2]));

    // Reference model: memory contents as of issue order, plus responses scheduled by absolute cycle.
    logic [15:0] ref_mem   [NI][8];
    bit          ref_known [NI][8];
    bit          sched_v   [NI][16];
    logic [15:0] sched_d   [NI][16];
    bit          sched_k   [NI][16];
    bit          exp_v [NI];
    logic [15:0] exp_d [NI];
    bit          exp_k [NI];

    bit          rq_wv [NI];
    logic [2:0]  rq_wa [NI];
    logic [15:0] rq_wd [NI];
    bit          rq_rv [NI];
    logic [2:0]  rq_ra [NI];

    int cyc;
    int checks;
    int failures;

    task automatic clear_requests();
        for (int i = 0; i < NI; i++) begin
            rq_wv[i] = 1'b0; rq_wa[i] = '0; rq_wd[i] = '0;
            rq_rv[i] = 1'b0; rq_ra[i] = '0;
        end
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < NI; i++) begin
            wv[i] = 1'b0; wa[i] = '0; wd[i] = '0;
            rv[i] = 1'b0; ra[i] = '0;
        end
    endtask

    // One clock: drive queued requests just after posedge, update the model, settle expectations at negedge.
    task automatic cycle();
        int slot;
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < NI; i++) begin
            wv[i] = rq_wv[i]; wa[i] = rq_wa[i]; wd[i] = rq_wd[i];
            rv[i] = rq_rv[i]; ra[i] = rq_ra[i];
            if (rq_rv[i]) begin
                slot = (cyc + LAT[i]) % 16;
                sched_v[i][slot] = 1'b1;
                if (BYP && rq_wv[i] && (rq_wa[i] == rq_ra[i])) begin
                    sched_d[i][slot] = rq_wd[i];
                    sched_k[i][slot] = 1'b1;
                end else begin
                    sched_d[i][slot] = ref_mem[i][rq_ra[i]];
                    sched_k[i][slot] = ref_known[i][rq_ra[i]];
                end
            end
            if (rq_wv[i]) begin
                ref_mem[i][rq_wa[i]]   = rq_wd[i];
                ref_known[i][rq_wa[i]] = 1'b1;
            end
        end
        clear_requests();
        @(negedge clk);
        slot = cyc % 16;
        for (int i = 0; i < NI; i++) begin
            exp_v[i] = sched_v[i][slot];
            exp_d[i] = sched_d[i][slot];
            exp_k[i] = sched_k[i][slot];
            sched_v[i][slot] = 1'b0;
        end
    endtask

    task automatic assert_reset();
        idle_inputs();
        clear_requests();
        #2 rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            for (int a = 0; a < 8; a++) begin
                ref_known[i][a] = (EMR[i] != 0);
                if (EMR[i] != 0) ref_mem[i][a] = '0;
            end
            for (int s = 0; s < 16; s++) sched_v[i][s] = 1'b0;
        end
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (rdv[i] !== 1'b0 || rdd[i] !== 16'h0) begin
                failures++;
                $display("FAIL reset_init inst%0d valid=%b data=%h required valid=0 data=0000", i, rdv[i], rdd[i]);
            end
        end
        release_reset();
        rq_wv[2] = 1'b1; rq_wa[2] = 3'd1; rq_wd[2] = 16'h0A0A;
        cycle();
        cycle();
        cycle();
        for (int k = 0; k < 4; k++) begin
            rq_rv[2] = 1'b1; rq_ra[2] = 3'd1;
            cycle();
        end
        checks++;
        if (rdv[2] !== 1'b1 || rdd[2] !== 16'h0A0A) begin
            failures++;
            $display("FAIL reset_prefill valid=%b data=%h required valid=1 data=0a0a", rdv[2], rdd[2]);
        end
        assert_reset();
        #1;
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (rdv[i] !== 1'b0 || rdd[i] !== 16'h0) begin
                failures++;
                $display("FAIL reset_async inst%0d valid=%b data=%h required valid=0 data=0000", i, rdv[i], rdd[i]);
            end
        end
        release_reset();
        for (int k = 0; k < 6; k++) begin
            cycle();
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (rdv[i] !== 1'b0 || rdd[i] !== 16'h0) begin
                    failures++;
                    $display("FAIL reset_flush inst%0d k=%0d valid=%b data=%h required valid=0 data=0000", i, k, rdv[i], rdd[i]);
                end
            end
        end
    endtask

    task automatic test_basic();
        rq_wv[0] = 1'b1; rq_wa[0] = 3'd3; rq_wd[0] = 16'hBEEF;
        cycle();
        checks++;
        if (rdv[0] !== 1'b0 || rdd[0] !== 16'h0) begin
            failures++;
            $display("FAIL basic_idle valid=%b data=%h required valid=0 data=0000", rdv[0], rdd[0]);
        end
        rq_rv[0] = 1'b1; rq_ra[0] = 3'd3;
        cycle();
        checks++;
        if (rdv[0] !== 1'b1 || rdd[0] !== 16'hBEEF) begin
            failures++;
            $display("FAIL basic_read valid=%b data=%h required valid=1 data=beef", rdv[0], rdd[0]);
        end
        rq_wv[0] = 1'b1; rq_wa[0] = 3'd7; rq_wd[0] = 16'h0123;
        rq_rv[0] = 1'b1; rq_ra[0] = 3'd3;
        cycle();
        checks++;
        if (rdv[0] !== 1'b1 || rdd[0] !== 16'hBEEF) begin
            failures++;
            $display("FAIL basic_indep valid=%b data=%h required valid=1 data=beef", rdv[0], rdd[0]);
        end
        rq_rv[0] = 1'b1; rq_ra[0] = 3'd7;
        cycle();
        checks++;
        if (rdv[0] !== 1'b1 || rdd[0] !== 16'h0123) begin
            failures++;
            $display("FAIL basic_read7 valid=%b data=%h required valid=1 data=0123", rdv[0], rdd[0]);
        end
    endtask

    task automatic test_latency();
        logic [15:0] want;
        for (int k = 0; k < 9; k++) begin
            if (k == 0) begin rq_wv[1] = 1'b1; rq_wa[1] = 3'd5; rq_wd[1] = 16'h1234; end
            if (k == 3) begin rq_rv[1] = 1'b1; rq_ra[1] = 3'd5; end
            cycle();
            want = (k == 6) ? 16'h1234 : 16'h0000;
            checks++;
            if (rdv[1] !== (k == 6) || rdd[1] !== want) begin
                failures++;
                $display("FAIL latency k=%0d valid=%b data=%h required valid=%0d data=%h", k, rdv[1], rdd[1], (k == 6), want);
            end
        end
    endtask

    task automatic test_collision();
        logic [15:0] want;
        rq_wv[0] = 1'b1; rq_wa[0] = 3'd2; rq_wd[0] = 16'h5555;
        cycle();
        rq_wv[0] = 1'b1; rq_wa[0] = 3'd2; rq_wd[0] = 16'hAAAA;
        rq_rv[0] = 1'b1; rq_ra[0] = 3'd2;
        cycle();
        want = BYP ? 16'hAAAA : 16'h5555;
        checks++;
        if (rdv[0] !== 1'b1 || rdd[0] !== want) begin
            failures++;
            $display("FAIL collision valid=%b data=%h required valid=1 data=%h", rdv[0], rdd[0], want);
        end
        rq_rv[0] = 1'b1; rq_ra[0] = 3'd2;
        cycle();
        checks++;
        if (rdv[0] !== 1'b1 || rdd[0] !== 16'hAAAA) begin
            failures++;
            $display("FAIL collision_after valid=%b data=%h required valid=1 data=aaaa", rdv[0], rdd[0]);
        end
    endtask

    task automatic test_back_to_back();
        bit want_v;
        logic [15:0] want_d;
        for (int k = 0; k < 13; k++) begin
            if (k < 8) begin
                rq_wv[2] = 1'b1; rq_wa[2] = 3'(k % 4); rq_wd[2] = 16'(k);
            end
            if (k >= 1 && k <= 8) begin
                rq_rv[2] = 1'b1; rq_ra[2] = 3'((k - 1) % 4);
            end
            cycle();
            want_v = (k >= 4 && k <= 11);
            want_d = want_v ? 16'(k - 4) : 16'h0;
            checks++;
            if (rdv[2] !== want_v || rdd[2] !== want_d) begin
                failures++;
                $display("FAIL b2b k=%0d valid=%b data=%h required valid=%0d data=%h", k, rdv[2], rdd[2], want_v, want_d);
            end
        end
    endtask

    task automatic test_mem_reset();
        bit want_v;
        for (int a = 0; a < 8; a++) begin
            rq_wv[1] = 1'b1; rq_wa[1] = 3'(a); rq_wd[1] = 16'h00FF;
            cycle();
        end
        cycle();
        cycle();
        for (int k = 0; k < 4; k++) begin
            if (k == 0) begin rq_rv[1] = 1'b1; rq_ra[1] = 3'd0; end
            cycle();
        end
        checks++;
        if (rdv[1] !== 1'b1 || rdd[1] !== 16'h00FF) begin
            failures++;
            $display("FAIL memrst_prefill valid=%b data=%h required valid=1 data=00ff", rdv[1], rdd[1]);
        end
        assert_reset();
        release_reset();
        for (int k = 0; k < 12; k++) begin
            if (k < 8) begin rq_rv[1] = 1'b1; rq_ra[1] = 3'(k); end
            cycle();
            want_v = (k >= 3 && k <= 10);
            checks++;
            if (rdv[1] !== want_v || rdd[1] !== 16'h0) begin
                failures++;
                $display("FAIL memrst k=%0d valid=%b data=%h required valid=%0d data=0000", k, rdv[1], rdd[1], want_v);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NI; i++) begin
                rq_wv[i] = ($urandom_range(1) == 1);
                rq_wa[i] = 3'($urandom_range(DEP[i] - 1));
                rq_wd[i] = 16'($urandom);
                rq_rv[i] = ($urandom_range(1) == 1);
                rq_ra[i] = 3'($urandom_range(DEP[i] - 1));
                if ($urandom_range(3) == 0) rq_ra[i] = rq_wa[i];
            end
            cycle();
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (rdv[i] !== exp_v[i]) begin
                    failures++;
                    $display("FAIL rand_valid inst%0d cyc=%0d valid=%b required %0d", i, cyc, rdv[i], exp_v[i]);
                end else if (exp_v[i] && exp_k[i] && rdd[i] !== exp_d[i]) begin
                    failures++;
                    $display("FAIL rand_data inst%0d cyc=%0d data=%h required %h", i, cyc, rdd[i], exp_d[i]);
                end else if (!exp_v[i] && rdd[i] !== 16'h0) begin
                    failures++;
                    $display("FAIL rand_gate inst%0d cyc=%0d data=%h required 0000", i, cyc, rdd[i]);
                end
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        idle_inputs();
        clear_requests();
        for (int i = 0; i < NI; i++) begin
            for (int a = 0; a < 8; a++) begin
                ref_mem[i][a]   = '0;
                ref_known[i][a] = (EMR[i] != 0);
            end
            for (int s = 0; s < 16; s++) begin
                sched_v[i][s] = 1'b0;
                sched_d[i][s] = '0;
                sched_k[i][s] = 1'b0;
            end
            exp_v[i] = 1'b0; exp_d[i] = '0; exp_k[i] = 1'b0;
        end
        test_reset();
        test_basic();
        test_latency();
        test_collision();
        test_back_to_back();
        test_mem_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/br_ram_flops_1r1w_sync.md
Name: br_ram_flops_1r1w_sync

Overview:
- Single-clock 1R1W flop RAM.
- Responder to a FIFO/queue controller's RAM initiator port: accepts write and read-address requests and returns read data after a fixed, parameterized latency.
- Sits under single-clock FIFO controllers in the same way the dual-clock flop RAM sits under CDC FIFO controllers.
- Internal valid/data pipelines; no backpressure.

Parameters:
- Depth, 2, number of entries; must be >= 2.
- Width, 1, bits per entry; must be >= 1.
- AddressStages, 0, pipeline register stages on both the write path and the read-address path; must be >= 0.
- ReadDataStages, 0, pipeline register stages on the read-data path; must be >= 0.
- EnableMemReset, 0, if 1 the storage array is cleared to 0 on reset; if 0 the array is not reset.
- AddrWidth, $clog2(Depth), localparam.

Ports:
- clk  input  1  posedge-triggered clock.
- rst_n  input  1  asynchronous active-low reset.
- wr_valid  input  1  write request.
- wr_addr  input  AddrWidth  write address.
- wr_data  input  Width  write data.
- rd_addr_valid  input  1  read request.
- rd_addr  input  AddrWidth  read address.
- rd_data_valid  output  1  read response valid.
- rd_data  output  Width  read response data.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All write- and read-pipeline valid flops clear to 0, so rd_data_valid=0.
  - Read-data pipeline flops clear to 0, so rd_data=0.
  - Array cleared only when EnableMemReset=1.
  - Deassertion is synchronous to clk (the integrator supplies a synchronized deassert).
- Reset mid-operation: all in-flight reads and writes are dropped. No response is ever produced for a read accepted before reset.
- Write latency is AddressStages+1 cycles. wr_valid/addr/data pass through AddressStages flops, then the entry is updated on the next posedge. The array flop enable is the pipelined wr_valid.
- Read latency is AddressStages+ReadDataStages cycles:
  - rd_addr passes through AddressStages flops, then the array is read combinationally, then data passes through ReadDataStages flops.
  - rd_data_valid is rd_addr_valid delayed by the same number of cycles.
  - Latency 0 means purely combinational: rd_data_valid=rd_addr_valid, and rd_data=mem[rd_addr].
- rd_data equals 0 whenever rd_data_valid=0. Data is gated by the valid at each pipeline stage, so no X propagates.
- No handshake and no backpressure: every request is accepted every cycle; reads and writes may issue back-to-back.
- Simultaneous write and read to different addresses are independent.
- Simultaneous write and read to the same address, evaluated at the array stage: returns the old contents unless the optional bypass is enabled.
- Two writes in consecutive cycles to the same address: the last one wins.
- Reading an unwritten entry with EnableMemReset=0 is permitted but its data is undefined. The initiator guarantees it never consumes such data.
- Integration assertions: Depth>=2, Width>=1, stage counts >=0; wr_addr<Depth when wr_valid; rd_addr<Depth when rd_addr_valid; no unknowns on the valids after reset.

Optional Feature:
- Macro: BR_RAM_FLOPS_WR_RD_BYPASS_EN.
- Defined: a read and write to the same address at the array stage in the same cycle returns the new wr_data (write-first forwarding mux before the read-data pipeline). This reduces effective write-to-read latency by one cycle for FIFO cut-through.
- Undefined: read-first behaviour (old data). Add a cover that the same-address collision occurs.

Decomposition:
- Package br_ram_pkg: no typedefs beyond the constant for computing read latency (AddressStages+ReadDataStages) and write latency (AddressStages+1), shared with controllers.
- Natural sub-module: br_delay_valid_rst_n, a parameterized valid+data delay line (NumStages, Width, async active-low reset, data gated by valid). Instantiate it three times: write path, read-address path, read-data path.

Test Plan:
- Reset state: assert rst_n=0 mid-stream with 3 reads in flight (AddressStages=1, ReadDataStages=2) -> rd_data_valid=0 and rd_data=0 immediately; no response after rst_n=1.
- Basic write/read, Depth=8, Width=16, stages 0/0: write 0xBEEF@3, read @3 next cycle -> same-cycle rd_data_valid=1, rd_data=0xBEEF.
- Latency, AddressStages=2, ReadDataStages=1: write 0x1234@5 at cycle 0, read @5 at cycle 3 -> rd_data_valid=1 at cycle 6, rd_data=0x1234, and 0 in every other cycle.
- Collision, stages 0/0: write 0xAAAA@2 after earlier 0x5555@2, plus a same-cycle read @2 -> 0x5555 without the macro, 0xAAAA with BR_RAM_FLOPS_WR_RD_BYPASS_EN.
- Back-to-back streaming, Depth=4: write 0..7 to addresses 0..3 in wrap-around order while reading one cycle behind -> every read returns the latest write, with no bubbles or duplicates.
- EnableMemReset=1: write all entries 0xFF, reset, read all 8 addresses -> all 0x00.
